// File: rtl/work_loader_pkg.sv
// Shared types and constants for the SHA-256 work loader: job layout, word count and run state.
package work_loader_pkg;

   localparam int unsigned WORDS_PER_JOB  = 11;
   localparam int unsigned MIDSTATE_WORDS = 8;
   localparam int unsigned TAIL_WORDS     = WORDS_PER_JOB - MIDSTATE_WORDS;
   localparam int unsigned COUNT_W        = 4;

   typedef logic [31:0]        word_t;
   typedef logic [COUNT_W-1:0] count_t;

   localparam count_t LAST_IDX = count_t'(WORDS_PER_JOB - 1);

   typedef struct packed {
      word_t [MIDSTATE_WORDS-1:0] midstate;
      word_t [TAIL_WORDS-1:0]     tail;
   } job_t;

   typedef enum logic [0:0] {
      StIdle,
      StRun
   } run_state_e;

endpackage

// File: rtl/work_loader.sv
// Collects an 11-word mining job into a shadow buffer and commits it atomically to the outputs.
module work_loader
   import work_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data,
   input  logic        ready,
   input  logic        done,
   output logic [31:0] a,
   output logic [31:0] b,
   output logic [31:0] c,
   output logic [31:0] d,
   output logic [31:0] e,
   output logic [31:0] f,
   output logic [31:0] g,
   output logic [31:0] h,
   output logic [31:0] w0,
   output logic [31:0] w1,
   output logic [31:0] w2,
   output logic        start,
   output logic        running,
   output logic        pending
);

   count_t     count_q, count_d;
   word_t      shadow_q [WORDS_PER_JOB];
   job_t       job_q, job_d;
   logic       start_q, start_d;
   run_state_e state_q, state_d;
   logic       commit;

   assign commit = ready && (count_q == LAST_IDX);

   // Word counter: advances only on accepted words, wraps to 0 on commit.
   always_comb begin
      count_d = count_q;
      if (ready) begin
         count_d = commit ? '0 : count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Shadow contents are don't-care after reset, so it carries no reset.
   always_ff @(posedge clk) begin
      if (ready && !commit) begin
         shadow_q[count_q] <= data;
      end
   end

   // Commit takes words 0..9 from the shadow and the final word straight from the link.
   always_comb begin
      job_d   = job_q;
      start_d = commit;
      if (commit) begin
         for (int i = 0; i < MIDSTATE_WORDS; i++) begin
            job_d.midstate[i] = shadow_q[i];
         end
         for (int i = 0; i < TAIL_WORDS - 1; i++) begin
            job_d.tail[i] = shadow_q[MIDSTATE_WORDS + i];
         end
         job_d.tail[TAIL_WORDS-1] = data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         job_q   <= '0;
         start_q <= 1'b0;
      end else begin
         job_q   <= job_d;
         start_q <= start_d;
      end
   end

   // Run-state FSM: state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Run-state FSM: next state; a commit outranks a same-edge done.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (commit) state_d = StRun;
         end
         StRun: begin
            if (commit)    state_d = StRun;
            else if (done) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Run-state FSM: outputs.
   always_comb begin
      running = (state_q == StRun);
   end

   assign pending = (count_q != '0);
   assign start   = start_q;

   assign a  = job_q.midstate[0];
   assign b  = job_q.midstate[1];
   assign c  = job_q.midstate[2];
   assign d  = job_q.midstate[3];
   assign e  = job_q.midstate[4];
   assign f  = job_q.midstate[5];
   assign g  = job_q.midstate[6];
   assign h  = job_q.midstate[7];
   assign w0 = job_q.tail[0];
   assign w1 = job_q.tail[1];
   assign w2 = job_q.tail[2];

endmodule

// File: tb/tb_work_loader.sv
// Directed bench for work_loader: job assembly, gaps, double buffering, done handling, reset.
module tb_work_loader;

   logic        clk = 1'b0;
   logic        rst, ready, done;
   logic [31:0] data;
   logic [31:0] a, b, c, d, e, f, g, h, w0, w1, w2;
   logic        start, running, pending;

   int n_pass  = 0;
   int n_total = 0;

   work_loader dut (
      .clk     (clk),
      .rst     (rst),
      .data    (data),
      .ready   (ready),
      .done    (done),
      .a       (a),
      .b       (b),
      .c       (c),
      .d       (d),
      .e       (e),
      .f       (f),
      .g       (g),
      .h       (h),
      .w0      (w0),
      .w1      (w1),
      .w2      (w2),
      .start   (start),
      .running (running),
      .pending (pending)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      ready = 1'b0;
      done  = 1'b0;
      step();
      rst = 1'b0;
   endtask

   // Accept one word on the next edge, leaving ready low afterwards.
   task automatic send(input logic [31:0] w, input logic with_done);
      ready = 1'b1;
      data  = w;
      done  = with_done;
      step();
      ready = 1'b0;
      done  = 1'b0;
   endtask

   task automatic check_job(input string tag, input logic [31:0] base);
      check({tag, "_a"},  a,  base);
      check({tag, "_b"},  b,  base + 1);
      check({tag, "_c"},  c,  base + 2);
      check({tag, "_d"},  d,  base + 3);
      check({tag, "_e"},  e,  base + 4);
      check({tag, "_f"},  f,  base + 5);
      check({tag, "_g"},  g,  base + 6);
      check({tag, "_h"},  h,  base + 7);
      check({tag, "_w0"}, w0, base + 8);
      check({tag, "_w1"}, w1, base + 9);
      check({tag, "_w2"}, w2, base + 10);
   endtask

   initial begin
      int first_start, second_start, n_starts;
      data  = '0;
      rst   = 1'b0;
      ready = 1'b0;
      done  = 1'b0;

      // Reset state
      do_reset();
      check("rst_a", a, 32'h0);
      check("rst_w2", w2, 32'h0);
      check("rst_start", 32'(start), 32'h0);
      check("rst_running", 32'(running), 32'h0);
      check("rst_pending", 32'(pending), 32'h0);

      // Back-to-back words 1..11
      ready = 1'b1;
      for (int i = 1; i <= 11; i++) begin
         data = 32'(i);
         step();
         if (i == 10) begin
            check("b2b_nostart", 32'(start), 32'h0);
            check("b2b_pend10", 32'(pending), 32'h1);
            check("b2b_hold_a", a, 32'h0);
         end
      end
      ready = 1'b0;
      check("b2b_start", 32'(start), 32'h1);
      check("b2b_running", 32'(running), 32'h1);
      check("b2b_pending", 32'(pending), 32'h0);
      check_job("b2b", 32'h1);
      step();
      check("b2b_start_1cyc", 32'(start), 32'h0);
      check("b2b_a_held", a, 32'h1);

      // Same words with 3 idle cycles between
      do_reset();
      for (int i = 1; i <= 11; i++) begin
         send(32'(i), 1'b0);
         if (i < 11) begin
            check("gap_pending", 32'(pending), 32'h1);
            check("gap_nostart", 32'(start), 32'h0);
            for (int k = 0; k < 3; k++) step();
            check("gap_pending_idle", 32'(pending), 32'h1);
            check("gap_nostart_idle", 32'(start), 32'h0);
            check("gap_a_zero", a, 32'h0);
         end
      end
      check("gap_start", 32'(start), 32'h1);
      check("gap_pending0", 32'(pending), 32'h0);
      check_job("gap", 32'h1);

      // Job B loaded while A runs, done never asserted
      for (int i = 0; i < 11; i++) begin
         send(32'h101 + 32'(i), 1'b0);
         if (i < 10) begin
            check("dbl_a_held", a, 32'h1);
            check("dbl_w2_held", w2, 32'hB);
            check("dbl_nostart", 32'(start), 32'h0);
         end
      end
      check("dbl_start", 32'(start), 32'h1);
      check("dbl_running", 32'(running), 32'h1);
      check_job("dbl", 32'h101);

      // Done on the same edge as the commit: commit wins
      for (int i = 0; i < 11; i++) send(32'h201 + 32'(i), i == 10);
      check("dc_start", 32'(start), 32'h1);
      check("dc_running", 32'(running), 32'h1);
      check("dc_a", a, 32'h201);
      done = 1'b1;
      step();
      done = 1'b0;
      check("done_running", 32'(running), 32'h0);
      check("done_start", 32'(start), 32'h0);

      // Done while idle is ignored
      done = 1'b1;
      step();
      done = 1'b0;
      check("idle_done_running", 32'(running), 32'h0);
      check("idle_done_a", a, 32'h201);
      check("idle_done_w2", w2, 32'h20B);

      // Reset mid-job discards the partial load
      for (int i = 0; i < 5; i++) send(32'h301 + 32'(i), 1'b0);
      check("part_pending", 32'(pending), 32'h1);
      rst   = 1'b1;
      ready = 1'b1;
      data  = 32'hDEAD;
      done  = 1'b1;
      step();
      rst   = 1'b0;
      ready = 1'b0;
      done  = 1'b0;
      check("part_rst_pending", 32'(pending), 32'h0);
      check("part_rst_a", a, 32'h0);
      check("part_rst_running", 32'(running), 32'h0);
      for (int i = 0; i < 11; i++) begin
         send(32'hA0 + 32'(i), 1'b0);
         if (i == 9) check("part_nostart", 32'(start), 32'h0);
      end
      check("part_start", 32'(start), 32'h1);
      check_job("part", 32'hA0);

      // 22 consecutive words: two starts 11 cycles apart
      first_start  = -1;
      second_start = -1;
      n_starts     = 0;
      ready        = 1'b1;
      for (int cyc = 0; cyc < 24; cyc++) begin
         data = 32'h400 + 32'(cyc);
         if (cyc >= 22) ready = 1'b0;
         step();
         if (start) begin
            n_starts++;
            if (first_start < 0) first_start = cyc;
            else second_start = cyc;
         end
      end
      ready = 1'b0;
      check("bb_nstarts", 32'(n_starts), 32'd2);
      check("bb_first", 32'(first_start), 32'd10);
      check("bb_spacing", 32'(second_start - first_start), 32'd11);
      check("bb_a", a, 32'h40B);
      check("bb_w2", w2, 32'h415);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/work_loader.md
WORK_LOADER -- requirements
Module: work_loader

Interface
REQ-001 SHALL have one clock and one synchronous, active-high reset.
REQ-002 SHALL have port: clk  input  1  system clock; all logic on posedge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port: data  input  32  job word from host link.
REQ-005 SHALL have port: ready  input  1  data holds a valid word this cycle.
REQ-006 SHALL have port: done  input  1  downstream nonce search finished (success or exhausted).
REQ-007 SHALL have ports: a, b, c, d, e, f, g, h  output  32 each  committed SHA-256 midstate words 0..7.
REQ-008 SHALL have ports: w0, w1, w2  output  32 each  committed header tail words 8..10.
REQ-009 SHALL have port: start  output  1  one-cycle pulse on each job commit; drives the index generator's start.
REQ-010 SHALL have port: running  output  1  a committed job is being searched.
REQ-011 SHALL have port: pending  output  1  partial job held in the shadow buffer (count != 0).

Function
REQ-012 SHALL accept one job as 11 consecutive ready words: order 0..7 -> a..h, 8..10 -> w0..w2.
REQ-013 SHALL sample data only on edges where ready=1; ready gaps of any length SHALL leave count and shadow unchanged.
REQ-014 SHALL hold a 4-bit word count, range 0..10, incremented per accepted word.
REQ-015 SHALL write accepted words 0..9 into an 11-entry shadow buffer, not into the outputs.
REQ-016 On the edge accepting word 10, SHALL load all 11 outputs at once: shadow words 0..9, plus word 10 taken directly from data.
REQ-017 On the same edge as REQ-016, SHALL reset count to 0 and drive start=1 for exactly the following cycle.
REQ-018 Outputs a..h and w0..w2 SHALL be valid in the same cycle start=1, and SHALL stay constant until the next commit.
REQ-019 running SHALL be set by each commit, and cleared on an edge with done=1 and no commit.
REQ-020 If done=1 and a commit occur on the same edge, commit SHALL win: running=1 and start pulses.
REQ-021 done while running=0 SHALL be ignored.
REQ-022 Loading SHALL continue during running=1 (double buffering); a new commit SHALL replace the active job, with no wait for done.
REQ-023 Back-to-back jobs (22 consecutive ready cycles) SHALL produce two start pulses exactly 11 cycles apart.
REQ-024 pending SHALL equal (count != 0), combinationally from the count register.

Reset
REQ-025 On rst=1 at a clock edge, SHALL set count=0, shadow contents don't-care, and a..h, w0..w2=0.
REQ-026 On the same reset edge, SHALL set start=0, running=0, pending=0.
REQ-027 rst SHALL override ready and done on the same edge; a partial load SHALL be discarded.
REQ-028 The first ready word after reset deasserts SHALL be taken as word 0.

Structure
REQ-029 The shared package SHALL hold: WORDS_PER_JOB=11, MIDSTATE_WORDS=8, word_t (32-bit), and a job_t struct (midstate[8], tail[3]).
REQ-030 Implementation SHALL be a single module with no sub-modules; the shadow buffer SHALL be a flop array indexed by count.
REQ-031 The outputs SHALL come directly from registers, with no combinational path from data to outputs.

Verification
REQ-032 Reset, then 11 back-to-back words 0x00000001..0x0000000B -> start=1 one cycle after word 11, a=0x1 .. h=0x8, w0=0x9, w1=0xA, w2=0xB, running=1.
REQ-033 Same 11 words with 3 idle cycles between each pair -> identical outputs; start pulses once, only after word 11; pending=1 from word 1 until commit.
REQ-034 Job A committed, then 11 words of job B while running, done never asserted -> a..w2 keep job A values until B's commit edge, then switch to B; second start pulse.
REQ-035 Running job, done=1 pulsed in the same cycle as B's 11th word -> running stays 1, start=1; then done=1 alone -> running=0 next cycle.
REQ-036 rst asserted after 5 words of a job, then 11 new words 0xA0..0xAA -> a=0xA0, w2=0xAA; no start pulse until the 11th new word.
REQ-037 done=1 with running=0 -> no output change, running stays 0.
